syscall_unit: RTL and testbench
===============================

# syscall_unit

Hardware syscall handler for the pipelined MIPS CPU. When the control unit decodes `SYSCALL`, it samples `$v0`/`$a0` and stalls the pipeline. It then services the call: decimal print of `$a0`, a NUL-terminated string walk through data memory, or program exit. Output characters leave as an 8-bit valid/ready byte stream to a console or UART sink, so programs run without testbench-side syscall emulation.

## Interface
- `MAX_STR`, 1024: maximum bytes emitted per `print_string` before forced termination.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sys_req` in 1: control unit has `SYSCALL` in decode; held high while stalled.
- `sys_v0` in 32: register `$v0`, service code.
- `sys_a0` in 32: register `$a0`, argument (signed int or byte address).
- `stall` out 1: freeze PC/IF/ID while a syscall is in service.
- `dm_rd_en` out 1: data-memory read strobe.
- `dm_addr` out 30: word address, equal to byte address `[31:2]`.
- `dm_rdata` in 32: read word, valid the cycle after `dm_rd_en`.
- `tx_valid` out 1: output byte valid.
- `tx_data` out 8: ASCII byte.
- `tx_ready` in 1: sink accepts the byte when `tx_valid & tx_ready` at the clock edge.
- `halt` out 1: sticky, program exited.
- `err` out 1: sticky, invalid code or string overrun.

## Operation
- States: IDLE, STR_RD, STR_CHK, STR_SEND, INT_DIV, INT_SIGN, INT_SEND, DONE, HALT.
- IDLE with `sys_req=1` latches `v0`, `a0` and dispatches on `v0`:
  - `v0=1`: go to INT_DIV.
  - `v0=4`: latch `ptr=a0` and go to STR_RD.
  - `v0=10`: go to HALT.
  - Any other code: set `err` and go to DONE.
- `stall = (state==IDLE & sys_req) | (state!=IDLE & state!=DONE)`. It is combinational so the CPU freezes in the same cycle as the request.
- DONE lasts one cycle with `stall=0` and `sys_req` ignored, which lets the held `SYSCALL` retire without re-triggering. DONE then returns to IDLE.
- String path:
  - STR_RD drives `dm_rd_en=1`, `dm_addr=ptr[31:2]`.
  - STR_CHK selects byte `dm_rdata[8*ptr[1:0]+:8]` (little-endian lanes).
  - If that byte is 0x00, go to DONE.
  - Otherwise load `tx_data`, set `tx_valid`, and go to STR_SEND.
  - STR_SEND holds until accepted, then `ptr+1` and go to STR_RD.
  - After `MAX_STR` bytes are emitted without a NUL: set `err` and go to DONE.
- Integer path:
  - Magnitude is `|a0|` as unsigned 32-bit, so `0x80000000` gives 2147483648.
  - INT_DIV pushes `mag%10` into a 10-entry digit buffer and sets `mag=mag/10`, one digit per cycle, until `mag==0`. Value 0 yields one digit.
  - INT_SIGN emits `'-'` (0x2D) if `a0[31]`, otherwise it is skipped in 0 cycles.
  - INT_SEND emits digits most significant first as `0x30+d`, then goes to DONE.
  - No leading zeros, no padding, no newline.
- HALT is terminal: `halt=1`, `stall=1`, no output. Only `rst` leaves it.
- `err` is cleared only by reset.

## Timing
- Reset values: `stall=0`, `dm_rd_en=0`, `dm_addr=0`, `tx_valid=0`, `tx_data=0`, `halt=0`, `err=0`, state IDLE.
- All outputs except `stall` are registered.
- Reset is asynchronous: asserting `rst` mid-service drops `tx_valid` immediately and aborts. A partial string or number is not resumed.
- Handshake rules:
  - Once `tx_valid` rises, `tx_data` is stable and `tx_valid` stays high until the accepting edge.
  - `tx_valid` does not depend combinationally on `tx_ready`.
- String throughput: 3 cycles per byte with `tx_ready=1` (RD, CHK, SEND). The terminating NUL costs RD plus CHK.
- Integer latency: request-to-first-byte is 1 + digit count cycles. Bytes then stream at 1 per cycle with `tx_ready=1`.
- Stall duration is from the request cycle through the last accepting edge or NUL check. Stall is low during DONE.
- Write-back hazard: the control unit raises `sys_req` only after pending writes to `$v0`/`$a0` have committed.

## Test plan
- `v0=1`, `a0=0` -> single byte 0x30, then DONE. `stall` high for exactly 3 cycles.
- `v0=1`, `a0=0x80000000` -> bytes `"-2147483648"`, 11 bytes. `a0=305` -> `"305"`.
- `v0=4`, `a0=0x0000_1001`, memory holds `"Hi\n\0"` across a word boundary -> bytes 0x48, 0x69, 0x0A, then DONE. The `dm_addr` sequence is 0x400, 0x400, 0x400, 0x401.
- Backpressure: `tx_ready=0` for 5 cycles during `"Hi"` -> `tx_data` stays 0x48 and `tx_valid` stays high throughout. No bytes are lost or duplicated.
- `v0=10` -> `halt=1` next cycle, `stall` stays 1, no tx. `v0=7` -> `err=1`, one DONE cycle, IDLE.
- `rst` low mid-string -> all outputs 0 asynchronously. After release, a new `v0=1`, `a0=42` emits `"42"` correctly.

Source files
------------

// File: rtl/syscall_unit.sv
// Hardware SYSCALL service engine: decimal print, NUL-terminated string print and exit.
// Characters leave as a valid/ready byte stream. The CPU is stalled while a call is in service.
module syscall_unit #(
  parameter int MAX_STR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys_req,
  input  logic [31:0] sys_v0,
  input  logic [31:0] sys_a0,
  output logic        stall,
  output logic        dm_rd_en,
  output logic [29:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic        err
);

  localparam int CW = $clog2(MAX_STR + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_STR_RD, S_STR_CHK, S_STR_SEND,
    S_INT_DIV, S_INT_SIGN, S_INT_SEND, S_DONE, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic          neg_q, neg_d;
  logic [31:0]   mag_q, mag_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    didx_q, didx_d;
  logic [3:0]    dig_q [10];
  logic [3:0]    dig_d [10];
  logic          dm_rd_en_q, dm_rd_en_d;
  logic [29:0]   dm_addr_q, dm_addr_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          halt_q, halt_d;
  logic          err_q, err_d;

  logic [31:0] abs_a0, mag_div, ptr_inc;
  logic [3:0]  mag_rem, didx_dec;
  logic [7:0]  str_byte;
  logic        tx_acc;

  // Two's-complement negate leaves 0x80000000 unchanged, which is its correct unsigned magnitude.
  assign abs_a0   = sys_a0[31] ? (~sys_a0 + 32'd1) : sys_a0;
  assign mag_div  = mag_q / 32'd10;
  assign mag_rem  = 4'(mag_q % 32'd10);
  assign ptr_inc  = ptr_q + 32'd1;
  assign didx_dec = didx_q - 4'd1;
  assign tx_acc   = tx_valid_q & tx_ready;

  always_comb begin
    str_byte = dm_rdata[7:0];
    case (ptr_q[1:0])
      2'd0: str_byte = dm_rdata[7:0];
      2'd1: str_byte = dm_rdata[15:8];
      2'd2: str_byte = dm_rdata[23:16];
      2'd3: str_byte = dm_rdata[31:24];
      default: str_byte = dm_rdata[7:0];
    endcase
  end

  // Gated by rst so the stall request falls with the asynchronous reset even if sys_req is held.
  assign stall = rst & (((state_q == S_IDLE) & sys_req) |
                        ((state_q != S_IDLE) & (state_q != S_DONE)));

  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    mag_d      = mag_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    didx_d     = didx_q;
    dig_d      = dig_q;
    dm_rd_en_d = dm_rd_en_q;
    dm_addr_d  = dm_addr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    halt_d     = halt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (sys_req) begin
          case (sys_v0)
            32'd1: begin
              mag_d   = abs_a0;
              neg_d   = sys_a0[31];
              didx_d  = 4'd0;
              state_d = S_INT_DIV;
            end
            32'd4: begin
              ptr_d      = sys_a0;
              cnt_d      = '0;
              dm_rd_en_d = 1'b1;
              dm_addr_d  = sys_a0[31:2];
              state_d    = S_STR_RD;
            end
            32'd10: begin
              halt_d  = 1'b1;
              state_d = S_HALT;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_STR_RD: begin
        dm_rd_en_d = 1'b0;
        state_d    = S_STR_CHK;
      end

      S_STR_CHK: begin
        if (str_byte == 8'h00) begin
          state_d = S_DONE;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = str_byte;
          state_d    = S_STR_SEND;
        end
      end

      S_STR_SEND: begin
        if (tx_acc) begin
          tx_valid_d = 1'b0;
          if (cnt_q == CW'(MAX_STR - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            ptr_d      = ptr_inc;
            dm_rd_en_d = 1'b1;
            dm_addr_d  = ptr_inc[31:2];
            state_d    = S_STR_RD;
          end
        end
      end

      // Digits are produced least significant first. didx ends up pointing at the leading digit.
      S_INT_DIV: begin
        dig_d[didx_q] = mag_rem;
        mag_d         = mag_div;
        if (mag_div == 32'd0) begin
          tx_valid_d = 1'b1;
          if (neg_q) begin
            tx_data_d = 8'h2D;
            state_d   = S_INT_SIGN;
          end else begin
            tx_data_d = 8'h30 + {4'h0, mag_rem};
            state_d   = S_INT_SEND;
          end
        end else begin
          didx_d = didx_q + 4'd1;
        end
      end

      S_INT_SIGN: begin
        if (tx_acc) begin
          tx_data_d = 8'h30 + {4'h0, dig_q[didx_q]};
          state_d   = S_INT_SEND;
        end
      end

      S_INT_SEND: begin
        if (tx_acc) begin
          if (didx_q == 4'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            didx_d    = didx_dec;
            tx_data_d = 8'h30 + {4'h0, dig_q[didx_dec]};
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      didx_q     <= '0;
      dm_rd_en_q <= 1'b0;
      dm_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      neg_q      <= neg_d;
      mag_q      <= mag_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      didx_q     <= didx_d;
      dm_rd_en_q <= dm_rd_en_d;
      dm_addr_q  <= dm_addr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  // Digit storage is pure data, always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    dig_q <= dig_d;
  end

  assign dm_rd_en = dm_rd_en_q;
  assign dm_addr  = dm_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign halt     = halt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: vector table plus hand sequences, with a byte scoreboard.
module tb_syscall_unit;

  localparam int MAX_STR = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sys_req = 1'b0;
  logic [31:0] sys_v0 = '0;
  logic [31:0] sys_a0 = '0;
  logic        stall;
  logic        dm_rd_en;
  logic [29:0] dm_addr;
  logic [31:0] dm_rdata = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        halt;
  logic        err;

  syscall_unit #(.MAX_STR(MAX_STR)) dut (
    .clk(clk), .rst(rst), .sys_req(sys_req), .sys_v0(sys_v0), .sys_a0(sys_a0),
    .stall(stall), .dm_rd_en(dm_rd_en), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  // Byte-addressed data memory with a one-cycle registered read.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (dm_rd_en)
      dm_rdata <= {mem[{dm_addr[10:0], 2'd3}], mem[{dm_addr[10:0], 2'd2}],
                   mem[{dm_addr[10:0], 2'd1}], mem[{dm_addr[10:0], 2'd0}]};
  end

  int checks = 0;
  int failures = 0;
  byte unsigned exp_q[$];
  logic [29:0]  addr_log[$];

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    int          hold;
    string       exp_str;
    bit          exp_err;
    int          exp_stall;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; sys_req = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one SYSCALL at a negedge and act as CPU + sink until the DONE cycle.
  task automatic run_call(input string tag, input logic [31:0] v0, input logic [31:0] a0,
                          input string exp_str, input bit exp_err, input int exp_stall,
                          input int exp_lat, input int hold);
    int cyc, stall_cnt, first, held, nbytes;
    bit done, prev_wait;
    logic [7:0] prev_data;
    byte unsigned b;
    for (int i = 0; i < exp_str.len(); i++) exp_q.push_back(exp_str[i]);
    sys_v0 = v0; sys_a0 = a0; sys_req = 1'b1;
    cyc = 0; stall_cnt = 0; first = -1; held = 0; nbytes = 0;
    done = 1'b0; prev_wait = 1'b0; prev_data = '0;
    addr_log.delete();
    while (!done && cyc < 5000) begin
      if (prev_wait) begin
        chk({tag, "_hold_valid"}, {31'd0, tx_valid}, 32'd1);
        chk({tag, "_hold_data"}, {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && first < 0) first = cyc;
      tx_ready = !(tx_valid && held < hold);
      if (tx_valid && !tx_ready) held++;
      if (dm_rd_en) addr_log.push_back(dm_addr);
      #1;
      if (stall) stall_cnt++;
      if (tx_valid && tx_ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s_extra_byte actual=0x%0h required=none", tag, tx_data);
        end else begin
          b = exp_q.pop_front();
          chk({tag, "_byte"}, {24'd0, tx_data}, {24'd0, b});
        end
      end
      prev_wait = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (!stall) begin
        done = 1'b1;
        sys_req = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b1;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=stall_high required=done_within_5000", tag);
      sys_req = 1'b0;
    end
    chk({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    chk({tag, "_first_byte_cycle"}, first, exp_lat);
    chk({tag, "_missing_bytes"}, exp_q.size(), 32'd0);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    exp_q.delete();
    $display("call %s v0=%0d a0=0x%08h bytes=%0d stall=%0d err=%0b", tag, v0, a0, nbytes, stall_cnt, err);
  endtask

  initial begin
    string big;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h41;
    mem[13'h1001] = 8'h48; mem[13'h1002] = 8'h69; mem[13'h1003] = 8'h0A; mem[13'h1004] = 8'h00;
    mem[13'h1103] = 8'h6F; mem[13'h1104] = 8'h6B; mem[13'h1105] = 8'h21; mem[13'h1106] = 8'h00;

    //            v0      a0             hold  expected         err  stall lat
    vecs.push_back('{32'd1, 32'h0000_0000, 0, "0",             1'b0,  3,  2});
    vecs.push_back('{32'd1, 32'h8000_0000, 0, "-2147483648",   1'b0, 22, 11});
    vecs.push_back('{32'd1, 32'd305,       0, "305",           1'b0,  7,  4});
    vecs.push_back('{32'd1, 32'hFFFF_FFF9, 0, "-7",            1'b0,  4,  2});
    vecs.push_back('{32'd1, 32'h7FFF_FFFF, 0, "2147483647",    1'b0, 21, 11});
    vecs.push_back('{32'd4, 32'h0000_1001, 0, "Hi\n",          1'b0, 12,  3});
    vecs.push_back('{32'd4, 32'h0000_1001, 5, "Hi\n",          1'b0, 17,  3});
    vecs.push_back('{32'd4, 32'h0000_1103, 0, "ok!",           1'b0, 12,  3});
    vecs.push_back('{32'd4, 32'h0000_1200, 0, "",              1'b0,  3, -1});
    vecs.push_back('{32'd7, 32'h0000_0000, 0, "",              1'b1,  1, -1});
    vecs.push_back('{32'd0, 32'h0000_0005, 0, "",              1'b1,  1, -1});

    // Reset state, checked with sys_req held high.
    sys_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dm_rd_en", {31'd0, dm_rd_en}, 32'd0);
    chk("rst_dm_addr", {2'd0, dm_addr}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    sys_req = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      run_call($sformatf("vec%0d", i), vecs[i].v0, vecs[i].a0, vecs[i].exp_str,
               vecs[i].exp_err, vecs[i].exp_stall, vecs[i].exp_lat, vecs[i].hold);
    end

    // Word-address sequence of the string walk across a word boundary.
    do_reset();
    run_call("hi_addr", 32'd4, 32'h0000_1001, "Hi\n", 1'b0, 12, 3, 0);
    chk("hi_addr_count", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      chk("hi_addr0", {2'd0, addr_log[0]}, 32'h400);
      chk("hi_addr1", {2'd0, addr_log[1]}, 32'h400);
      chk("hi_addr2", {2'd0, addr_log[2]}, 32'h400);
      chk("hi_addr3", {2'd0, addr_log[3]}, 32'h401);
    end

    // err is sticky across later good calls.
    do_reset();
    run_call("bad_code", 32'd2, 32'd0, "", 1'b1, 1, -1, 0);
    run_call("after_err", 32'd1, 32'd9, "9", 1'b1, 3, 2, 0);

    // Exit: halt the next cycle, stall held, no output, sys_req ignored.
    do_reset();
    sys_v0 = 32'd10; sys_a0 = 32'd0; sys_req = 1'b1;
    #1;
    chk("halt_req_stall", {31'd0, stall}, 32'd1);
    chk("halt_req_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    chk("halt_next", {31'd0, halt}, 32'd1);
    sys_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_stall", {31'd0, stall}, 32'd1);
      chk("halt_sticky", {31'd0, halt}, 32'd1);
      chk("halt_no_tx", {31'd0, tx_valid}, 32'd0);
    end
    $display("call halt v0=10 halt=%0b stall=%0b", halt, stall);

    // String overrun: MAX_STR bytes without a NUL.
    do_reset();
    big = "";
    for (int i = 0; i < MAX_STR; i++) big = {big, "A"};
    run_call("overrun", 32'd4, 32'd0, big, 1'b1, 1 + 3 * MAX_STR, 3, 0);

    // Asynchronous reset mid-string, then a clean integer print.
    do_reset();
    sys_v0 = 32'd4; sys_a0 = 32'h0000_1001; sys_req = 1'b1; tx_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_valid", {31'd0, tx_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_tx_data", {24'd0, tx_data}, 32'd0);
    chk("abort_dm_rd_en", {31'd0, dm_rd_en}, 32'd0);
    chk("abort_dm_addr", {2'd0, dm_addr}, 32'd0);
    chk("abort_halt", {31'd0, halt}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1; sys_req = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    run_call("after_abort", 32'd1, 32'd42, "42", 1'b0, 5, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
